// File: rtl/sram_arbiter.sv
// Two-requester arbiter sharing one split address/data SRAM port between fetch (I) and data (D).
// One transaction in flight; D wins ties; completed data is held until the pipeline advances.
module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [3:0]        d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    input  logic              adv,
    output logic              m_req,
    output logic              m_wr,
    output logic [3:0]        m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              grant_r;     // 1'b1 = D, 1'b0 = I
    logic              i_done_r;
    logic              d_done_r;
    logic [DATA_W-1:0] i_hold_r;
    logic [DATA_W-1:0] d_hold_r;
    logic              wr_r;
    logic [3:0]        wen_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              m_req_r;
    logic              i_pend_s;
    logic              d_pend_s;
    logic              issue_i_s;
    logic              issue_d_s;
    logic              complete_s;

    assign i_pend_s   = i_req & ~i_done_r;
    assign d_pend_s   = d_req & ~d_done_r;
    assign complete_s = (state_r == ST_DATA) & m_data_ok;

    // Next-state selection and grant decision
    always_comb begin
        state_s   = state_r;
        issue_i_s = 1'b0;
        issue_d_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (d_pend_s) begin
                    state_s   = ST_ADDR;
                    issue_d_s = 1'b1;
                end else if (i_pend_s) begin
                    state_s   = ST_ADDR;
                    issue_i_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_addr_ok) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (m_data_ok) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request fields, done flags and hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            grant_r  <= 1'b0;
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
            i_hold_r <= {DATA_W{1'b0}};
            d_hold_r <= {DATA_W{1'b0}};
            wr_r     <= 1'b0;
            wen_r    <= 4'b0000;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            m_req_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            m_req_r <= (state_s == ST_ADDR);
            if (issue_d_s) begin
                grant_r <= 1'b1;
                wr_r    <= d_wr;
                wen_r   <= d_wen;
                addr_r  <= d_addr;
                wdata_r <= d_wdata;
            end else if (issue_i_s) begin
                grant_r <= 1'b0;
                wr_r    <= 1'b0;
                wen_r   <= 4'b0000;
                addr_r  <= i_addr;
                wdata_r <= {DATA_W{1'b0}};
            end
            // adv wins: the bypassed data was consumed in this very cycle
            if (adv) begin
                i_done_r <= 1'b0;
                d_done_r <= 1'b0;
            end else if (complete_s) begin
                if (grant_r) begin
                    d_done_r <= 1'b1;
                end else begin
                    i_done_r <= 1'b1;
                end
            end
            if (complete_s && !grant_r) begin
                i_hold_r <= m_rdata;
            end else if (complete_s && grant_r && !wr_r) begin
                d_hold_r <= m_rdata;
            end
        end
    end

    assign m_req   = m_req_r;
    assign m_wr    = wr_r;
    assign m_wen   = wen_r;
    assign m_addr  = addr_r;
    assign m_wdata = wdata_r;

    assign i_stall = i_pend_s & ~(complete_s & ~grant_r);
    assign d_stall = d_pend_s & ~(complete_s & grant_r);
    assign i_rdata = (complete_s & ~grant_r) ? m_rdata : i_hold_r;
    assign d_rdata = (complete_s & grant_r) ? m_rdata : d_hold_r;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (F stage) and the data requester (M stage) of the 5-stage MIPS core.
- Runs one outstanding transaction at a time, using a split address/data handshake.
- Holds each requester's returned data until the pipeline advances.
- Generates the per-requester stall signals that the hazard unit ORs into stallF and stallM.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request (read only)
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched instruction
- i_stall  out  1  fetch not yet complete
- d_req  in  1  data access request
- d_wr  in  1  1 = store, 0 = load
- d_wen  in  4  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_stall  out  1  data access not yet complete
- adv  in  1  pipeline advances this cycle (no stall anywhere)
- m_req  out  1  memory address-phase request
- m_wr  out  1  memory write
- m_wen  out  4  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_addr_ok  in  1  address accepted
- m_data_ok  in  1  data phase complete
- m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, grant=I;
  - i_done=d_done=0;
  - i_hold=d_hold=0;
  - all latched request fields 0;
  - m_req=0 and the other m_* outputs 0.
- i_stall/d_stall then follow their equations (combinational on i_req/d_req).
- Pending conditions: i_pend = i_req & ~i_done; d_pend = d_req & ~d_done.
- FSM states and transitions:
  - IDLE: if d_pend, grant=D, latch d_wr/d_wen/d_addr/d_wdata, go to ADDR. Else if i_pend, grant=I, latch i_addr with wr=0 and wen=0, go to ADDR. Else stay in IDLE. D always wins a simultaneous request.
  - ADDR: m_req=1 with the latched fields, which stay stable while waiting. On m_addr_ok, go to DATA; otherwise stay.
  - DATA: m_req=0. On m_data_ok: set the granted requester's done flag; for a load or fetch, capture m_rdata into its hold register (a store leaves the hold unchanged); go to IDLE. Otherwise stay.
- m_data_ok or m_addr_ok arriving outside DATA or ADDR respectively is ignored.
- Input changes after the grant do not affect the transaction in flight.
- Completion bypass: in the m_data_ok cycle of the granted requester:
  - its stall is already 0;
  - its rdata output equals m_rdata combinationally.
  - In all other cycles, i_rdata=i_hold and d_rdata=d_hold.
- Stall equations:
  - i_stall = i_pend & ~(state==DATA & grant==I & m_data_ok)
  - d_stall: same form, with d_pend and grant==D.
- Done-flag clearing: adv=1 clears both done flags at the clock edge. adv has priority over setting a flag in the same cycle, since the bypassed data was consumed that cycle. Hold registers are not cleared.
- Latency: request in IDLE at cycle 0 → m_req at cycle 1 → earliest m_data_ok at cycle 2. Stall is therefore high for cycles 0–1 and low from cycle 2.
- Back-to-back: after a D completion, a pending I is granted in the IDLE cycle that follows (one idle bubble). There is no fixed starvation bound: I is served whenever D is not pending in IDLE.
- A done requester whose req stays high is not re-issued until adv clears its flag.
- Reset mid-transaction abandons the transaction. Any late m_data_ok arrives in IDLE and is ignored.

Test Plan:
- Fetch only: i_req=1, i_addr=0xBFC00000; m_addr_ok at cycle 1, m_data_ok with m_rdata=0x24080001 at cycle 2. Required: m_addr=0xBFC00000 and m_wr=0 at cycle 1; i_stall 1,1,0; i_rdata=0x24080001 at cycle 2.
- Simultaneous requests: i_req=d_req=1 with d_addr=0x80001000 (load). Required: first m_addr=0x80001000; fetch issued only after the D completion plus one IDLE cycle; i_stall stays 1 throughout.
- Store: d_wr=1, d_wen=4'b0011, d_wdata=0x0000BEEF, addr_ok delayed 3 cycles. Required: m_req held 3 cycles with stable m_wen/m_wdata; d_rdata unchanged after completion.
- Hold without adv: I completes with 0x11111111 while D is still pending (adv=0). Required: i_stall=0 and i_rdata=0x11111111 held; no second fetch until adv=1, after which a re-fetch occurs if i_req remains 1.
- Reset in DATA: rst=0 for one cycle, then m_data_ok=1. Required: state IDLE, both done flags 0, response ignored, stalls reflect req only.
